// File: rtl/v_mul_su_input_control.sv
// Operand-preparation stage for the vector Vedic multiplier.
// Two-stage elastic valid/ready pipeline:
//   S1 registers raw operands, opcode and normalised precision.
//   S2 registers per-element magnitudes and per-16-bit-chunk sign signals.
// Optional build macro: V_MUL_SU_STALL_CNT_EN adds a saturating stall counter output.
module v_mul_su_input_control #(
  parameter int WIDTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               operand_a,
  input  logic [DATA_W-1:0]               operand_b,
  input  logic [1:0]                      opcode,
  input  logic [1:0]                      precision,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               mag_a,
  output logic [DATA_W-1:0]               mag_b,
  output logic [(2*DATA_W/WIDTH)-1:0]     sign_signal_a,
  output logic [(2*DATA_W/WIDTH)-1:0]     sign_signal_b,
  output logic [1:0]                      opcode_q,
  output logic [1:0]                      precision_q
`ifdef V_MUL_SU_STALL_CNT_EN
  ,
  output logic [15:0]                     stall_cnt
`endif
);

  // Stage 1 state
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic [1:0]        s1_op_q, s1_prec_q;
  logic [1:0]        s1_prec_d;

  // Stage 2 state
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_mag_a_q, s2_mag_b_q;
  logic [3:0]        s2_sign_a_q, s2_sign_b_q;
  logic [1:0]        s2_op_q, s2_prec_q;

  // Combinational next-state for stage 2
  logic [35:0]       prep_a_d, prep_b_d;
  logic              a_signed, b_signed;
  logic              s1_adv, s2_adv;

  // Returns {sign[3:0], magnitude[31:0]}; each element negated within its own width.
  function automatic logic [35:0] prep(input logic [31:0] x, input logic sgn,
                                       input logic [1:0] prec);
    logic [31:0] m;
    logic [3:0]  s;
    m = x;
    s = '0;
    case (prec)
      2'b01: begin
        for (int unsigned h = 0; h < 2; h++) begin
          if (sgn && x[16*h+15]) begin
            m[16*h +: 16] = -x[16*h +: 16];
            s[2*h +: 2]   = '1;
          end
        end
      end
      2'b10: begin
        if (sgn && x[31]) begin
          m = -x;
          s = '1;
        end
      end
      default: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (sgn && x[8*i+7]) begin
            m[8*i +: 8] = -x[8*i +: 8];
            s[i]        = 1'b1;
          end
        end
      end
    endcase
    return {s, m};
  endfunction

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = rst_n && !flush && s1_adv;
  assign s1_prec_d = (precision == 2'b11) ? 2'b00 : precision;

  // Signedness decode and per-element magnitude/sign preparation from S1 contents
  always_comb begin
    a_signed = (s1_op_q != 2'b10);
    b_signed = !s1_op_q[1];
    prep_a_d = prep(s1_a_q, a_signed, s1_prec_q);
    prep_b_d = prep(s1_b_q, b_signed, s1_prec_q);
  end

  // Stage 1 register: captures raw operands when S1 may advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_prec_q  <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= operand_a;
        s1_b_q    <= operand_b;
        s1_op_q   <= opcode;
        s1_prec_q <= s1_prec_d;
      end
    end
  end

  // Stage 2 register: captures prepared magnitudes/signs when S2 may advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_mag_a_q  <= '0;
      s2_mag_b_q  <= '0;
      s2_sign_a_q <= '0;
      s2_sign_b_q <= '0;
      s2_op_q     <= '0;
      s2_prec_q   <= '0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mag_a_q  <= prep_a_d[31:0];
        s2_mag_b_q  <= prep_b_d[31:0];
        s2_sign_a_q <= prep_a_d[35:32];
        s2_sign_b_q <= prep_b_d[35:32];
        s2_op_q     <= s1_op_q;
        s2_prec_q   <= s1_prec_q;
      end
    end
  end

  assign out_valid     = s2_valid_q;
  assign mag_a         = s2_mag_a_q;
  assign mag_b         = s2_mag_b_q;
  assign sign_signal_a = s2_sign_a_q;
  assign sign_signal_b = s2_sign_b_q;
  assign opcode_q      = s2_op_q;
  assign precision_q   = s2_prec_q;

`ifdef V_MUL_SU_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where output is held by downstream backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (flush) begin
      stall_cnt_q <= '0;
    end else if (s2_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_v_mul_su_input_control.sv
// Self-checking bench for v_mul_su_input_control (scoreboard + directed checks).
module tb_v_mul_su_input_control;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand_a, operand_b;
  logic [1:0]  opcode, precision;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mag_a, mag_b;
  logic [3:0]  sign_signal_a, sign_signal_b;
  logic [1:0]  opcode_q, precision_q;
`ifdef V_MUL_SU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [75:0] sb[$];
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [76:0] prev_out   = '0;

  v_mul_su_input_control #(.WIDTH(16), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .opcode        (opcode),
    .precision     (precision),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .mag_a         (mag_a),
    .mag_b         (mag_b),
    .sign_signal_a (sign_signal_a),
    .sign_signal_b (sign_signal_b),
    .opcode_q      (opcode_q),
    .precision_q   (precision_q)
`ifdef V_MUL_SU_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: element-wise arithmetic on integers, {sa, sb, op, prec, mag_a, mag_b}
  function automatic logic [75:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, input logic [1:0] pr);
    logic [1:0]        p;
    int                w;
    longint unsigned   mask;
    logic [31:0]       ma, mb;
    logic [3:0]        sa, sbs;
    p    = (pr == 2'b11) ? 2'b00 : pr;
    w    = (p == 2'b00) ? 8 : (p == 2'b01) ? 16 : 32;
    mask = (64'd1 << w) - 64'd1;
    ma = '0; mb = '0; sa = '0; sbs = '0;
    for (int e = 0; e < 32 / w; e++) begin
      longint unsigned ea, eb, ra, rb;
      bit na, nb;
      ea = ({32'd0, a} >> (e * w)) & mask;
      eb = ({32'd0, b} >> (e * w)) & mask;
      na = (op != 2'b10) && (((ea >> (w - 1)) & 64'd1) != 0);
      nb = (op == 2'b00 || op == 2'b01) && (((eb >> (w - 1)) & 64'd1) != 0);
      ra = na ? ((mask + 64'd1 - ea) & mask) : ea;
      rb = nb ? ((mask + 64'd1 - eb) & mask) : eb;
      ma = ma | 32'(ra << (e * w));
      mb = mb | 32'(rb << (e * w));
      for (int j = 0; j < 4; j++) begin
        if ((j * 8) / w == e) begin
          sa[j]  = na;
          sbs[j] = nb;
        end
      end
    end
    return {sa, sbs, op, p, ma, mb};
  endfunction

  function automatic logic [75:0] dut_out();
    return {sign_signal_a, sign_signal_b, opcode_q, precision_q, mag_a, mag_b};
  endfunction

  // Scoreboard monitor: push on input transfer, pop/compare on output transfer, hold check on stall
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
      prev_flush = 1'b0;
    end else begin
      if (prev_stall && !prev_flush)
        chk("hold_while_stalled", {3'b0, out_valid, dut_out()}, {3'b0, prev_out});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", {79'd0, out_valid}, 80'd0);
        else                chk("scoreboard_data", {4'd0, dut_out()}, {4'd0, sb.pop_front()});
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(operand_a, operand_b, opcode, precision));
      prev_stall = out_valid && !out_ready;
      prev_flush = flush;
      prev_out   = {out_valid, dut_out()};
    end
  end

  // Drive one bundle and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [1:0] pr);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    operand_a = a;
    operand_b = b;
    opcode    = op;
    precision = pr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", {79'd0, in_ready}, 80'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx;
    bit  acc, saw_block;
    logic [31:0] fa, fb;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    operand_a = '0; operand_b = '0; opcode = '0; precision = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {79'd0, out_valid}, 80'd0);
    chk("reset_outputs", {4'd0, dut_out()}, 80'd0);
    chk("reset_in_ready", {79'd0, in_ready}, 80'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", {79'd0, in_ready}, 80'd1);
    out_ready = 1'b1;

    // 8-bit MUL, latency
    send(32'hFF80_0203, 32'h0102_FEFD, 2'b00, 2'b00);
    chk("latency_edge_n", {79'd0, out_valid}, 80'd0);
    @(posedge clk); #1;
    chk("latency_edge_n1", {79'd0, out_valid}, 80'd1);
    chk("mul8", {4'd0, dut_out()},
        {4'd0, 4'b1100, 4'b0011, 2'b00, 2'b00, 32'h0180_0203, 32'h0102_0203});

    // 16-bit MULHSU
    send(32'h8000_FFFF, 32'hFFFF_0001, 2'b11, 2'b01);
    @(posedge clk); #1;
    chk("mulhsu16", {4'd0, dut_out()},
        {4'd0, 4'b1111, 4'b0000, 2'b11, 2'b01, 32'h8000_0001, 32'hFFFF_0001});

    // 32-bit MULHU then MULH on all-ones
    send(32'hFFFF_FFFF, 32'h1234_5678, 2'b10, 2'b10);
    @(posedge clk); #1;
    chk("mulhu32", {4'd0, dut_out()},
        {4'd0, 4'b0000, 4'b0000, 2'b10, 2'b10, 32'hFFFF_FFFF, 32'h1234_5678});
    send(32'hFFFF_FFFF, 32'h8000_0000, 2'b01, 2'b10);
    @(posedge clk); #1;
    chk("mulh32", {4'd0, dut_out()},
        {4'd0, 4'b1111, 4'b1111, 2'b01, 2'b10, 32'h0000_0001, 32'h8000_0000});
    @(posedge clk); #1;

    // Backpressure: 5 bundles, out_ready low for cycles 3..6
    idx = 0; saw_block = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (!in_valid && idx < 5) begin
        in_valid  = 1'b1;
        operand_a = $urandom;
        operand_b = $urandom;
        opcode    = 2'($urandom_range(0, 3));
        precision = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      if (in_valid && !in_ready) saw_block = 1'b1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    chk("bp_in_ready_dropped", {79'd0, saw_block}, 80'd1);
    chk("bp_all_accepted", 80'(idx), 80'd5);
    chk("bp_drained", 80'(sb.size()), 80'd0);
`ifdef V_MUL_SU_STALL_CNT_EN
    chk("bp_stall_cnt", {64'd0, stall_cnt}, 80'd4);
`endif

    // Flush with both stages full and in_valid high
    out_ready = 1'b0;
    send(32'h1111_2222, 32'h3333_4444, 2'b00, 2'b00);
    send(32'h5555_6666, 32'h7777_8888, 2'b01, 2'b01);
    fa = 32'h7F80_0001; fb = 32'h8000_8000;
    in_valid = 1'b1; operand_a = fa; operand_b = fb; opcode = 2'b00; precision = 2'b01;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {79'd0, in_ready}, 80'd0);
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", {79'd0, out_valid}, 80'd0);
`ifdef V_MUL_SU_STALL_CNT_EN
    chk("flush_stall_cnt", {64'd0, stall_cnt}, 80'd0);
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_flush_edge1", {79'd0, out_valid}, 80'd0);
    @(posedge clk); #1;
    chk("post_flush_edge2", {79'd0, out_valid}, 80'd1);
    chk("post_flush_data", {4'd0, dut_out()}, {4'd0, model(fa, fb, 2'b00, 2'b01)});
    @(posedge clk); #1;

    // Reset mid-stream
    for (int i = 0; i < 4; i++) send($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", {79'd0, out_valid}, 80'd0);
    chk("async_reset_outputs", {4'd0, dut_out()}, 80'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("restart_in_ready", {79'd0, in_ready}, 80'd1);
    send(32'hFF80_0203, 32'h0102_FEFD, 2'b00, 2'b11);
    @(posedge clk); #1;
    chk("prec11_as_8bit", {4'd0, dut_out()},
        {4'd0, 4'b1100, 4'b0011, 2'b00, 2'b00, 32'h0180_0203, 32'h0102_0203});

    // Random stream with random backpressure
    idx = 0;
    for (int c = 0; c < 300 && idx < 25; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid) begin
        in_valid  = 1'b1;
        operand_a = $urandom;
        operand_b = $urandom;
        opcode    = 2'($urandom_range(0, 3));
        precision = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("rand_all_accepted", 80'(idx), 80'd25);
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    chk("rand_drained", 80'(sb.size()), 80'd0);
    chk("rand_out_idle", {79'd0, out_valid}, 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/v_mul_su_input_control.md
Name: v_mul_su_input_control

Overview:
Upstream operand-preparation stage of the vector Vedic multiplier, placed ahead of the multiplier block and output control.
- Takes raw 32-bit operands with opcode and precision.
- Converts each signed, negative element to its unsigned magnitude.
- Produces the per-16-bit-product-chunk sign signals that output control uses to re-apply two's complement.
- Registers everything through a 2-stage elastic valid/ready pipeline with synchronous flush.

Parameters:
- WIDTH, 16, product chunk width that sign signals index; fixed at 16 (4 chunks of the 64-bit product).
- DATA_W, 32, operand width; only 32 supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of both pipeline stages
- in_valid  in  1  operand bundle valid
- in_ready  out  1  stage 1 can accept
- operand_a  in  32  multiplicand vector
- operand_b  in  32  multiplier vector
- opcode  in  2  00 MUL, 01 MULH, 10 MULHU, 11 MULHSU
- precision  in  2  00 8-bit, 01 16-bit, 10 32-bit, 11 treated as 00
- out_valid  out  1  prepared bundle valid
- out_ready  in  1  downstream accepts
- mag_a  out  32  per-element magnitude of A
- mag_b  out  32  per-element magnitude of B
- sign_signal_a  out  4  per-chunk sign of A
- sign_signal_b  out  4  per-chunk sign of B
- opcode_q  out  2  opcode aligned with data
- precision_q  out  2  precision aligned with data

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and internal registers are 0. in_ready is 1 once reset deasserts.
- Stage 1 (S1): registers operand_a, operand_b, opcode and precision; precision 11 is normalised to 00.
- Stage 2 (S2): registers mag_a, mag_b and the sign signals computed from S1; drives the outputs.
- Handshake:
  - Transfer occurs when valid && ready.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready equals the S1 advance condition (combinational).
  - Full throughput: 1 bundle/cycle when out_ready is held high.
  - Latency: a bundle accepted at edge N has out_valid high after edge N+1.
- Stability: while out_valid && !out_ready, all outputs hold unchanged. No bundle is dropped or duplicated.
- Signedness:
  - A is signed for opcodes 00, 01 and 11; unsigned for 10.
  - B is signed for opcodes 00 and 01; unsigned for 10 and 11.
- Element sign e_sign = signed && element MSB:
  - 8-bit: bits 7/15/23/31.
  - 16-bit: bits 15/31.
  - 32-bit: bit 31.
- Magnitude: element is negated (two's complement within element width) when e_sign=1, otherwise passed through.
  - Most-negative value maps to itself, e.g. 0x80 gives 0x80, read as unsigned 128.
  - No carry crosses element boundaries.
- Sign signal mapping:
  - 8-bit: sign_signal[i] = e_sign of byte i.
  - 16-bit: [1:0] = halfword0 sign, [3:2] = halfword1 sign.
  - 32-bit: all 4 bits = word sign.
- Flush:
  - Clears s1_valid and s2_valid at the next edge and wins over any simultaneous transfer.
  - in_ready is 0 during the flush cycle.
  - Data registers need not clear.
- Reset mid-operation: in-flight bundles are discarded; out_valid is 0 immediately (asynchronous).

Optional Feature:
- Macro: V_MUL_SU_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0].
  - Increments each cycle out_valid && !out_ready.
  - Saturates at 0xFFFF.
  - Cleared by rst_n and by flush.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- 8-bit MUL: a=0xFF80_0203, b=0x0102_FEFD, one beat → after 2 edges:
  - mag_a=0x0180_0203
  - mag_b=0x0102_0203
  - sign_signal_a=4'b1100
  - sign_signal_b=4'b0011
- 16-bit MULHSU: a=0x8000_FFFF, b=0xFFFF_0001 → mag_a=0x8000_0001, mag_b=0xFFFF_0001, sign_signal_a=4'b1111, sign_signal_b=4'b0000.
- 32-bit MULHU: a=0xFFFF_FFFF → mag_a=0xFFFF_FFFF, sign_signal_a=0; same operand with MULH → mag_a=0x0000_0001, sign_signal_a=4'b1111.
- Backpressure: stream 5 bundles with out_ready low for cycles 3–6 → in_ready drops after both stages fill; all 5 emerge in order, unchanged while stalled; stall_cnt=4 when the macro is enabled.
- Flush with in_valid high and both stages full → out_valid=0 next cycle; no flushed bundle ever appears; the next accepted bundle arrives 2 edges later.
- Assert rst_n low mid-stream for 1 cycle → all outputs 0 asynchronously; stream restarts cleanly; precision=11 input behaves as 8-bit.
